// File: rtl/serial_read.sv
// UART receiver: oversamples the async rx line, assembles LSB-first 1-start/N-data/1-stop frames.
// Latency: data_ready rises BAUD_DIVIDER/2 + (DATA_BITS+1)*BAUD_DIVIDER + 1 clks after rx_s is seen low.
// Backpressure: none on the line; an unread word is overwritten and reported with a 1-clk overrun pulse.
module serial_read #(
    parameter int BAUD_DIVIDER = 234,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 read_ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_ready,
    output logic                 RiP,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(BAUD_DIVIDER);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIVIDER / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIVIDER - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q;
    logic                 rx_s_q;
    logic [1:0]           hist_q;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 data_ready_q, data_ready_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 maj;
    logic                 load;

    // Two-flop synchronizer plus a short history of the synchronized line for the vote.
    // Line idles high, so everything resets to 1 to avoid a false start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            hist_q  <= 2'b11;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            hist_q  <= {hist_q[0], rx_s_q};
        end
    end

    // 2-of-3 vote over the current and two previous synchronized samples.
    always_comb begin
        maj = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_ready_q <= data_ready_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Frame FSM: half-bit check of the start bit, then one mid-bit sample per full bit period.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_cnt_q == CNT_HALF) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    state_d    = maj ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baud_cnt_q == CNT_LAST) begin
                    baud_cnt_d           = '0;
                    shift_d              = shift_q >> 1;
                    shift_d[DATA_BITS-1] = maj;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (baud_cnt_q == CNT_LAST) begin
                    // Leave mid-stop-bit so a start edge right after the stop bit is caught.
                    baud_cnt_d  = '0;
                    state_d     = S_IDLE;
                    load        = maj;
                    frame_err_d = ~maj;
                end
            end
            default: begin
                state_d    = S_IDLE;
                baud_cnt_d = '0;
            end
        endcase
    end

    // Consumer handshake: a completed word wins over read_ack; overrun only when the old word was never taken.
    always_comb begin
        data_d       = data_q;
        data_ready_d = data_ready_q;
        overrun_d    = 1'b0;
        if (load) begin
            data_d       = shift_q;
            data_ready_d = 1'b1;
            overrun_d    = data_ready_q & ~read_ack;
        end else if (read_ack) begin
            data_ready_d = 1'b0;
        end
    end

    assign data       = data_q;
    assign data_ready = data_ready_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign RiP        = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_read.sv
// Bench for serial_read: frames are driven bit by bit on rx; each frame pushes its expected
// completion cycle/outcome into a queue, and a cycle monitor keeps a handshake model and compares.
module tb_serial_read;

    localparam int BD   = 16;
    localparam int DB   = 8;
    // First clk edge sampling the start bit on the pin -> edge that raises data_ready.
    localparam int LAT  = BD / 2 + (DB + 1) * BD + 1 + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic          read_ack;
    logic [DB-1:0] data;
    logic          data_ready;
    logic          RiP;
    logic          frame_err;
    logic          overrun;

    serial_read #(.BAUD_DIVIDER(BD), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .read_ack   (read_ack),
        .data       (data),
        .data_ready (data_ready),
        .RiP        (RiP),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        bit            ferr;
        logic [DB-1:0] d;
    } exp_t;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    exp_t exp_q[$];
    win_t rip_q[$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int ack_mode  = 0;
    int ack_at    = -1;
    int last_rise = -1;
    int ovr_cnt   = 0;
    int fail_prints = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drives one frame LSB-first; p1 is the first clk edge that samples the start bit.
    task automatic send_frame(input logic [DB-1:0] d, input bit stop, output int p1);
        exp_t e;
        win_t w;
        p1     = cyc + 1;
        e.cyc  = p1 + LAT;
        e.ferr = !stop;
        e.d    = d;
        exp_q.push_back(e);
        w.lo = p1 + 2;
        w.hi = p1 + LAT - 1;
        rip_q.push_back(w);
        if (!stop) begin
            // The still-low stop bit looks like a fresh start edge and is then rejected at half-bit.
            w.lo = p1 + LAT + 1;
            w.hi = p1 + LAT + BD / 2 + 1;
            rip_q.push_back(w);
        end
        rx = 1'b0;
        tick(BD);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            tick(BD);
        end
        rx = stop;
        tick(BD);
        rx = 1'b1;
    endtask

    // read_ack driver: off, random, or a single pulse seen at clk edge ack_at.
    initial begin
        read_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ack_mode)
                1:       read_ack = ($urandom_range(5) == 0);
                2:       read_ack = (cyc + 1 == ack_at);
                default: read_ack = 1'b0;
            endcase
        end
    end

    // Monitor: reference handshake model advanced once per clk and compared against all outputs.
    initial begin
        logic          ack_e;
        logic          m_dr;
        logic [DB-1:0] m_data;
        logic          e_fe, e_ov, e_rip;
        logic          prev_dr;
        exp_t          e;
        m_dr    = 1'b0;
        m_data  = '0;
        prev_dr = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            ack_e = read_ack;
            @(negedge clk);
            e_fe = 1'b0;
            e_ov = 1'b0;
            if (!rst_n) begin
                m_dr   = 1'b0;
                m_data = '0;
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                if (e.ferr) begin
                    e_fe = 1'b1;
                end else begin
                    e_ov   = m_dr && !ack_e;
                    m_data = e.d;
                    m_dr   = 1'b1;
                end
            end else if (ack_e) begin
                m_dr = 1'b0;
            end
            while (rip_q.size() > 0 && rip_q[0].hi < cyc) void'(rip_q.pop_front());
            e_rip = rst_n && rip_q.size() > 0 && cyc >= rip_q[0].lo;

            checks++;
            if ({data, data_ready, RiP, frame_err, overrun} !== {m_data, m_dr, e_rip, e_fe, e_ov}) begin
                errors++;
                if (fail_prints < 30) begin
                    fail_prints++;
                    $display("FAIL outputs cycle %0d: data/dr/rip/ferr/ovr got %h/%b/%b/%b/%b expected %h/%b/%b/%b/%b",
                             cyc, data, data_ready, RiP, frame_err, overrun,
                             m_data, m_dr, e_rip, e_fe, e_ov);
                end
            end
            if (data_ready === 1'b1 && !prev_dr) last_rise = cyc;
            if (overrun === 1'b1) ovr_cnt++;
            prev_dr = (data_ready === 1'b1);
        end
    end

    initial begin
        int p1, p2, ovr0;
        win_t w;
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(5);
        rst_n = 1'b1;
        tick(5);

        // Single frame: value and exact latency.
        send_frame(8'hA5, 1'b1, p1);
        tick(4);
        check("latency_a5", last_rise - p1, LAT);
        check("data_a5", data, 8'hA5);
        ack_mode = 2;
        ack_at   = cyc + 3;
        tick(6);
        check("ack_clears_dr", data_ready, 1'b0);

        // Back-to-back frames, each acknowledged after it lands.
        ovr0   = ovr_cnt;
        ack_at = cyc + 1 + LAT + 2;
        send_frame(8'h3C, 1'b1, p1);
        ack_at = cyc + 1 + LAT + 2;
        send_frame(8'hC3, 1'b1, p2);
        tick(20);
        check("b2b_no_overrun", ovr_cnt - ovr0, 0);
        check("b2b_second_data", data, 8'hC3);

        // Short low glitch while idle.
        ack_mode = 0;
        w.lo = cyc + 1 + 2;
        w.hi = cyc + 1 + BD / 2 + 2;
        rip_q.push_back(w);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        check("glitch_no_dr", data_ready, 1'b0);

        // Bad stop bit.
        send_frame(8'h55, 1'b0, p1);
        tick(30);
        check("ferr_data_kept", data, 8'hC3);

        // Unread word overwritten, then overwrite with ack on the completion edge.
        ovr0 = ovr_cnt;
        send_frame(8'h11, 1'b1, p1);
        tick(3);
        send_frame(8'h22, 1'b1, p1);
        tick(10);
        check("overrun_once", ovr_cnt - ovr0, 1);
        check("overrun_data", data, 8'h22);
        ovr0     = ovr_cnt;
        ack_mode = 2;
        ack_at   = cyc + 1 + LAT;
        send_frame(8'h44, 1'b1, p1);
        tick(10);
        check("ack_at_done_no_ovr", ovr_cnt - ovr0, 0);
        check("ack_at_done_dr", data_ready, 1'b1);

        // Reset in the middle of a frame, then a clean frame.
        ack_mode = 0;
        p1   = cyc + 1;
        w.lo = p1 + 2;
        w.hi = p1 + 62;
        rip_q.push_back(w);
        rx = 1'b0;
        tick(BD);
        rx = 1'b1;
        tick(3 * BD);
        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(20);
        check("after_reset_dr", data_ready, 1'b0);
        send_frame(8'h0F, 1'b1, p1);
        tick(10);
        check("after_reset_data", data, 8'h0F);

        // Randomized traffic with random acknowledges.
        ack_mode = 1;
        for (int n = 0; n < 40; n++) begin
            logic [DB-1:0] d;
            bit            stop;
            d    = DB'($urandom);
            stop = ($urandom_range(4) != 0);
            send_frame(d, stop, p1);
            if (stop) tick($urandom_range(11));
            else      tick(BD + $urandom_range(7));
        end
        ack_mode = 0;
        tick(30);
        check("all_frames_seen", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
